// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the RAM access controller.
// Imported by ram_access_ctrl and by anything that decodes its state.
package ram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_UNLOAD_RD,
        ST_UNLOAD_WAIT,
        ST_DONE
    } ctrl_state_t;

    localparam int          DEF_ADDR_W    = 16;
    localparam int          DEF_DATA_W    = 16;
    localparam logic [15:0] DEF_IMG_BASE  = 16'h0000;
    localparam int          DEF_IMG_WORDS = 256;
    localparam logic [15:0] DEF_RES_BASE  = 16'h0100;
    localparam int          DEF_RES_WORDS = 256;

endpackage

// File: rtl/ram_access_ctrl.sv
// Sequencer and arbiter for the single data RAM port: host load, processor run,
// host unload. The processor is gated by a clock enable rather than a gated clock.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] IMG_BASE  = ADDR_W'(DEF_IMG_BASE),
    parameter int                IMG_WORDS = DEF_IMG_WORDS,
    parameter logic [ADDR_W-1:0] RES_BASE  = ADDR_W'(DEF_RES_BASE),
    parameter int                RES_WORDS = DEF_RES_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [DATA_W-1:0] host_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              proc_ce,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic              proc_we,
    input  logic              proc_en,
    input  logic              proc_end,
    output logic [DATA_W-1:0] proc_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_WORDS - 1);
    localparam logic [ADDR_W-1:0] RES_LAST = ADDR_W'(RES_WORDS - 1);

    ctrl_state_t       state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic              out_valid_nx;
    logic [DATA_W-1:0] out_data_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
        end
    end

    // In LOAD host_ready is constant 1, so host_valid alone is the handshake.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = ST_LOAD;
                    cnt_nx   = '0;
                end
            end
            ST_LOAD: begin
                if (host_valid) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = IMG_BASE + cnt;
                    ram_wdata = host_data;
                    if (cnt == IMG_LAST) begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                ram_en    = proc_en;
                ram_we    = proc_we & proc_en;
                ram_addr  = proc_addr;
                ram_wdata = proc_wdata;
                if (proc_end) begin
                    state_nx = ST_UNLOAD_RD;
                end
            end
            ST_UNLOAD_RD: begin
                ram_en   = 1'b1;
                ram_addr = RES_BASE + cnt;
                state_nx = ST_UNLOAD_WAIT;
            end
            ST_UNLOAD_WAIT: begin
                // First WAIT cycle is the one where read data is valid.
                if (!out_valid) begin
                    out_valid_nx = 1'b1;
                    out_data_nx  = ram_rdata;
                end else if (out_ready) begin
                    out_valid_nx = 1'b0;
                    if (cnt == RES_LAST) begin
                        state_nx = ST_DONE;
                    end else begin
                        cnt_nx   = cnt + ADDR_W'(1);
                        state_nx = ST_UNLOAD_RD;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (abort) begin
            state_nx     = ST_IDLE;
            cnt_nx       = '0;
            out_valid_nx = 1'b0;
        end
    end

    assign host_ready = (state == ST_LOAD);
    assign proc_ce    = (state == ST_RUN);
    assign busy       = (state == ST_LOAD) || (state == ST_RUN) ||
                        (state == ST_UNLOAD_RD) || (state == ST_UNLOAD_WAIT);
    assign done       = (state == ST_DONE);
    assign proc_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: a small RAM model, expected-write and
// expected-unload queues popped by negedge monitors, plus directed timing checks.
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic        host_valid, host_ready;
    logic [15:0] host_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        busy, done, proc_ce;
    logic [15:0] proc_addr, proc_wdata, proc_rdata;
    logic        proc_we, proc_en, proc_end;
    logic [15:0] ram_addr, ram_wdata;
    logic        ram_we, ram_en;
    logic [15:0] ram_rdata = '0;

    logic        start_w, host_valid_w, host_ready_w;
    logic [15:0] host_data_w;
    logic        w_out_valid, w_busy, w_done, w_proc_ce, w_ram_we, w_ram_en;
    logic [15:0] w_out_data, w_proc_rdata, w_ram_addr, w_ram_wdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_wr[$];
    logic [31:0] exp_wr_w[$];
    logic [15:0] exp_out[$];
    logic [15:0] mem [0:65535];

    logic [31:0] wr_exp, wr_exp_w;
    logic [15:0] out_exp, stall_data;
    logic        stall_prev = 1'b0;

    always #5 clk = ~clk;

    ram_access_ctrl #(
        .ADDR_W(16), .DATA_W(16),
        .IMG_BASE(16'h0010), .IMG_WORDS(4),
        .RES_BASE(16'h0100), .RES_WORDS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .proc_ce(proc_ce),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_we(proc_we),
        .proc_en(proc_en), .proc_end(proc_end), .proc_rdata(proc_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_en(ram_en), .ram_rdata(ram_rdata)
    );

    ram_access_ctrl #(
        .ADDR_W(16), .DATA_W(16),
        .IMG_BASE(16'hFFFE), .IMG_WORDS(4),
        .RES_BASE(16'h0100), .RES_WORDS(2)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start_w), .abort(1'b0),
        .host_valid(host_valid_w), .host_ready(host_ready_w), .host_data(host_data_w),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
        .busy(w_busy), .done(w_done), .proc_ce(w_proc_ce),
        .proc_addr(16'h0000), .proc_wdata(16'h0000), .proc_we(1'b0),
        .proc_en(1'b0), .proc_end(1'b0), .proc_rdata(w_proc_rdata),
        .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata), .ram_we(w_ram_we),
        .ram_en(w_ram_en), .ram_rdata(16'h0000)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // RAM write monitor for the main instance.
    always @(negedge clk) begin
        if (ram_en && ram_we) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("[TB] FAIL ram_write: got unexpected write addr=%h data=%h, required no write",
                         ram_addr, ram_wdata);
            end else begin
                wr_exp = exp_wr.pop_front();
                if ({ram_addr, ram_wdata} !== wr_exp) begin
                    errors++;
                    $display("[TB] FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                             ram_addr, ram_wdata, wr_exp[31:16], wr_exp[15:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (w_ram_en && w_ram_we) begin
            checks++;
            if (exp_wr_w.size() == 0) begin
                errors++;
                $display("[TB] FAIL wrap_write: got unexpected write addr=%h data=%h, required no write",
                         w_ram_addr, w_ram_wdata);
            end else begin
                wr_exp_w = exp_wr_w.pop_front();
                if ({w_ram_addr, w_ram_wdata} !== wr_exp_w) begin
                    errors++;
                    $display("[TB] FAIL wrap_write: got addr=%h data=%h, required addr=%h data=%h",
                             w_ram_addr, w_ram_wdata, wr_exp_w[31:16], wr_exp_w[15:0]);
                end
            end
        end
    end

    // Unload monitor: handshake data against the queue, stall stability against last cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            if (exp_out.size() == 0) begin
                errors++;
                $display("[TB] FAIL out_word: got unexpected word %h, required none", out_data);
            end else begin
                out_exp = exp_out.pop_front();
                if (out_data !== out_exp) begin
                    errors++;
                    $display("[TB] FAIL out_word: got %h, required %h", out_data, out_exp);
                end
            end
        end else if (out_valid && stall_prev) begin
            checks++;
            if (out_data !== stall_data) begin
                errors++;
                $display("[TB] FAIL out_stable: got %h, required %h", out_data, stall_data);
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data);
        host_valid = 1'b1;
        host_data  = data;
        exp_wr.push_back({addr, data});
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_host_ready"}, 32'(host_ready), 0);
        checkOutput({tag, "_proc_ce"},    32'(proc_ce),    0);
        checkOutput({tag, "_busy"},       32'(busy),       0);
        checkOutput({tag, "_done"},       32'(done),       0);
        checkOutput({tag, "_ram_en"},     32'(ram_en),     0);
        checkOutput({tag, "_ram_we"},     32'(ram_we),     0);
        checkOutput({tag, "_ram_addr"},   32'(ram_addr),   0);
        checkOutput({tag, "_out_valid"},  32'(out_valid),  0);
        checkOutput({tag, "_out_data"},   32'(out_data),   0);
    endtask

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] wrap_addr [4];
        int          waited;
        wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        host_valid = 1'b0; host_data = '0; out_ready = 1'b0;
        proc_addr = '0; proc_wdata = '0; proc_we = 1'b0; proc_en = 1'b0; proc_end = 1'b0;
        start_w = 1'b0; host_valid_w = 1'b0; host_data_w = '0;
        repeat (2) tick();
        @(negedge clk);
        checkReset("por");
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-load with a write pending must drop that write.
        start = 1'b1; tick(); start = 1'b0;
        applyStimulus(16'h0010, 16'h0055); tick();
        applyStimulus(16'h0011, 16'h0056); tick();
        host_data = 16'h0057;
        rst_n = 1'b0;
        @(negedge clk);
        checkReset("mid_load_reset");
        tick(); tick();
        host_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Load four words with stalls.
        start = 1'b1; tick(); start = 1'b0;
        applyStimulus(16'h0010, 16'h00A1); tick();
        host_valid = 1'b0; tick();
        applyStimulus(16'h0011, 16'h00A2); tick();
        applyStimulus(16'h0012, 16'h00A3); tick();
        host_valid = 1'b0; tick(); tick();
        applyStimulus(16'h0013, 16'h00A4);
        @(negedge clk);
        checkOutput("proc_ce_before_last", 32'(proc_ce), 0);
        checkOutput("host_ready_load", 32'(host_ready), 1);
        tick();
        host_valid = 1'b0;
        @(negedge clk);
        checkOutput("proc_ce_after_load", 32'(proc_ce), 1);
        checkOutput("busy_run", 32'(busy), 1);
        checkOutput("host_ready_run", 32'(host_ready), 0);

        // Processor phase.
        tick();
        proc_en = 1'b0; proc_we = 1'b1; proc_addr = 16'h0200; proc_wdata = 16'h1111;
        tick();
        proc_en = 1'b1; proc_we = 1'b1; proc_addr = 16'h0100; proc_wdata = 16'hBEEF;
        exp_wr.push_back({16'h0100, 16'hBEEF});
        tick();
        proc_we = 1'b0;
        tick();
        proc_we = 1'b1; proc_addr = 16'h0101; proc_wdata = 16'hCAFE; proc_end = 1'b1;
        exp_wr.push_back({16'h0101, 16'hCAFE});
        exp_out.push_back(16'hBEEF);
        exp_out.push_back(16'hCAFE);
        @(negedge clk);
        checkOutput("proc_rdata", 32'(proc_rdata), 32'hBEEF);
        checkOutput("proc_ce_end_cycle", 32'(proc_ce), 1);
        tick();
        proc_end = 1'b0; proc_en = 1'b0; proc_we = 1'b0;
        @(negedge clk);
        checkOutput("proc_ce_after_end", 32'(proc_ce), 0);
        checkOutput("busy_unload", 32'(busy), 1);
        checkOutput("out_valid_rd", 32'(out_valid), 0);
        tick();
        @(negedge clk);
        checkOutput("out_valid_wait_entry", 32'(out_valid), 0);
        tick();
        @(negedge clk);
        checkOutput("out_valid_first", 32'(out_valid), 1);
        checkOutput("out_data_first", 32'(out_data), 32'hBEEF);
        repeat (4) tick();
        out_ready = 1'b1;
        waited = 0;
        while (!done && waited < 20) begin
            tick();
            waited++;
        end
        @(negedge clk);
        checkOutput("done_reached", 32'(done), 1);
        checkOutput("busy_done", 32'(busy), 0);
        checkOutput("ram_en_done", 32'(ram_en), 0);
        checkOutput("out_valid_done", 32'(out_valid), 0);
        checkOutput("out_queue_drained", 32'(exp_out.size()), 0);

        // Reload from DONE with proc_end held (ignored outside RUN), then start/abort.
        proc_end = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        applyStimulus(16'h0010, 16'h00B1); tick();
        applyStimulus(16'h0011, 16'h00B2); tick();
        applyStimulus(16'h0012, 16'h00B3); tick();
        applyStimulus(16'h0013, 16'h00B4); tick();
        host_valid = 1'b0; proc_end = 1'b0;
        @(negedge clk);
        checkOutput("proc_ce_reload", 32'(proc_ce), 1);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        @(negedge clk);
        checkOutput("start_in_run_ignored", 32'(proc_ce), 1);
        checkOutput("host_ready_in_run", 32'(host_ready), 0);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_proc_ce", 32'(proc_ce), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        applyStimulus(16'h0010, 16'h0077); tick();
        host_valid = 1'b0;
        @(negedge clk);
        checkOutput("host_ready_after_restart", 32'(host_ready), 1);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;

        // Address wrap on the second instance.
        start_w = 1'b1; tick(); start_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_valid_w = 1'b1;
            host_data_w  = 16'(i + 1);
            exp_wr_w.push_back({wrap_addr[i], 16'(i + 1)});
            tick();
        end
        host_valid_w = 1'b0;
        @(negedge clk);
        checkOutput("wrap_proc_ce", 32'(w_proc_ce), 1);

        tick();
        checkOutput("wr_queue_drained", 32'(exp_wr.size()), 0);
        checkOutput("wrap_queue_drained", 32'(exp_wr_w.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
